// File: rtl/vector_op_pkg.sv
// vector_op_pkg: register map, mode encodings and FSM state type shared by the vector op engine
package vector_op_pkg;
   localparam logic [15:0] REG_START  = 16'h00;
   localparam logic [15:0] REG_A_BASE = 16'h04;
   localparam logic [15:0] REG_B_BASE = 16'h08;
   localparam logic [15:0] REG_C_BASE = 16'h0C;
   localparam logic [15:0] REG_LEN    = 16'h10;
   localparam logic [15:0] REG_STATUS = 16'h14;
   typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_MIN, MODE_MAX} mode_t;
   typedef enum logic [2:0] {IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR, DONE} state_t;
endpackage

// File: rtl/vop_lane_alu.sv
// vop_lane_alu: one signed lane of add/sub/min/max; VOP_SATURATE_EN makes add/sub saturate instead of wrap
module vop_lane_alu
   import vector_op_pkg::*;
#(
   parameter int W = 32
) (
   input  mode_t              mode,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic        [W-1:0] y
);
   logic [W-1:0] arith;
`ifdef VOP_SATURATE_EN
   logic signed [W:0] s;
   always_comb begin
      s = (mode == MODE_SUB) ? {a[W-1], a} - {b[W-1], b} : {a[W-1], a} + {b[W-1], b};
      // sign bits disagree on overflow; the true sign picks the clamp value
      arith = (s[W] != s[W-1]) ? {s[W], {(W-1){~s[W]}}} : s[W-1:0];
   end
`else
   assign arith = (mode == MODE_SUB) ? a - b : a + b;
`endif
   assign y = (mode == MODE_MIN) ? ((a < b) ? a : b) :
              (mode == MODE_MAX) ? ((a < b) ? b : a) : arith;
endmodule

// File: rtl/vector_op_engine.sv
// vector_op_engine: register-driven C = op(A, B) over LEN signed lanes, one word at a time
// Optional macro VOP_SATURATE_EN selects saturating add/sub in the lane ALUs.
module vector_op_engine
   import vector_op_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 64,
   parameter int LANE_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    reg_wr_en,
   input  logic                    reg_rd_en,
   input  logic [15:0]             reg_addr,
   input  logic [31:0]             reg_wdata,
   output logic [31:0]             reg_rdata,
   output logic                    rd_req_valid,
   input  logic                    rd_req_ready,
   output logic [ADDR_WIDTH-1:0]   rd_req_addr,
   input  logic                    rd_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   rd_rsp_data,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_strb,
   output logic                    irq
);
   localparam int LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LB    = LANE_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(BYTES - 1);
   localparam logic [31:0] NL = 32'(LANES);

   state_t state, next;
   mode_t mode;
   logic [31:0] a_base, b_base, c_base, len, rem;
   logic [ADDR_WIDTH-1:0] a_lat, b_lat, c_lat, off;
   logic [DATA_WIDTH-1:0] a_word, b_word;
   logic done, start_err, start_wr, accept;

   assign start_wr = reg_wr_en && reg_addr == REG_START;
   assign accept   = start_wr && state == IDLE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= next;

   always_comb begin
      next = state;
      case (state)
         IDLE:    if (accept) next = (len == '0) ? DONE : RD_A;
         RD_A:    if (rd_req_ready) next = WAIT_A;
         WAIT_A:  if (rd_rsp_valid) next = RD_B;
         RD_B:    if (rd_req_ready) next = WAIT_B;
         WAIT_B:  if (rd_rsp_valid) next = WR;
         WR:      if (wr_ready) next = (rem > NL) ? RD_A : DONE;
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_base    <= '0;
         b_base    <= '0;
         c_base    <= '0;
         len       <= '0;
         rem       <= '0;
         mode      <= MODE_ADD;
         a_lat     <= '0;
         b_lat     <= '0;
         c_lat     <= '0;
         off       <= '0;
         a_word    <= '0;
         b_word    <= '0;
         done      <= 1'b0;
         start_err <= 1'b0;
         reg_rdata <= '0;
      end else begin
         if (reg_wr_en && reg_addr == REG_A_BASE) a_base <= reg_wdata;
         if (reg_wr_en && reg_addr == REG_B_BASE) b_base <= reg_wdata;
         if (reg_wr_en && reg_addr == REG_C_BASE) c_base <= reg_wdata;
         if (reg_wr_en && reg_addr == REG_LEN)    len    <= reg_wdata;
         // the job runs from snapshots so later register writes cannot disturb it
         if (accept) begin
            mode      <= mode_t'(reg_wdata[1:0]);
            a_lat     <= ADDR_WIDTH'(a_base) & AMASK;
            b_lat     <= ADDR_WIDTH'(b_base) & AMASK;
            c_lat     <= ADDR_WIDTH'(c_base) & AMASK;
            off       <= '0;
            rem       <= len;
            done      <= 1'b0;
            start_err <= 1'b0;
         end else if (start_wr) begin
            start_err <= 1'b1;
         end
         if (state == WAIT_A && rd_rsp_valid) a_word <= rd_rsp_data;
         if (state == WAIT_B && rd_rsp_valid) b_word <= rd_rsp_data;
         if (state == WR && wr_ready) begin
            off <= off + ADDR_WIDTH'(BYTES);
            rem <= (rem > NL) ? rem - NL : '0;
         end
         if (state == DONE) done <= 1'b1;
         if (reg_rd_en)
            reg_rdata <= (reg_addr == REG_A_BASE) ? a_base :
                         (reg_addr == REG_B_BASE) ? b_base :
                         (reg_addr == REG_C_BASE) ? c_base :
                         (reg_addr == REG_LEN)    ? len :
                         (reg_addr == REG_STATUS) ? {29'd0, start_err, done, state != IDLE} : '0;
      end
   end

   assign rd_req_valid = state == RD_A || state == RD_B;
   assign rd_req_addr  = ((state == RD_B) ? b_lat : a_lat) + off;
   assign wr_valid     = state == WR;
   assign wr_addr      = c_lat + off;
   assign irq          = state == DONE;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      vop_lane_alu #(.W(LANE_WIDTH)) u_alu (
         .mode (mode),
         .a    (a_word[i*LANE_WIDTH +: LANE_WIDTH]),
         .b    (b_word[i*LANE_WIDTH +: LANE_WIDTH]),
         .y    (wr_data[i*LANE_WIDTH +: LANE_WIDTH])
      );
      // a lane's bytes are enabled only while that lane index is still within the remaining count
      assign wr_strb[i*LB +: LB] = {LB{wr_valid && rem > 32'(i)}};
   end
endmodule

// File: tb/tb_vector_op_engine.sv
// tb_vector_op_engine: directed checks of the vector op engine with a stalling memory responder
module tb_vector_op_engine;
   localparam logic [15:0] R_START = 16'h00, R_A = 16'h04, R_B = 16'h08, R_C = 16'h0C,
                           R_LEN = 16'h10, R_STATUS = 16'h14;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         reg_wr_en, reg_rd_en;
   logic [15:0]  reg_addr;
   logic [31:0]  reg_wdata, reg_rdata;
   logic         rd_req_valid, rd_req_ready;
   logic [63:0]  rd_req_addr;
   logic         rd_rsp_valid;
   logic [255:0] rd_rsp_data;
   logic         wr_valid, wr_ready;
   logic [63:0]  wr_addr;
   logic [255:0] wr_data;
   logic [31:0]  wr_strb;
   logic         irq;

   vector_op_engine dut (
      .clk(clk), .rst_n(rst_n),
      .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb), .irq(irq)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int irq_cnt = 0, rd_hs = 0;
   logic stall = 1'b1, hold = 1'b0, any_rd = 1'b0, any_wr = 1'b0;
   logic [255:0] mem [256];
   logic [63:0]  pend [$];
   logic [63:0]  wa_q [$];
   logic [255:0] wd_q [$];
   logic [31:0]  ws_q [$];
   logic [255:0] nine = {8{32'd9}};

   // memory responder: drives readies and responses on the falling edge, then observes handshakes
   initial begin
      logic [63:0] pa;
      rd_req_ready = 1'b0;
      wr_ready = 1'b0;
      rd_rsp_valid = 1'b0;
      rd_rsp_data = '0;
      forever begin
         @(negedge clk);
         rd_req_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!hold && pend.size() != 0 && (!stall || $urandom_range(0, 1) == 1)) begin
            pa = pend.pop_front();
            rd_rsp_valid = 1'b1;
            rd_rsp_data = mem[pa[12:5]];
         end else begin
            rd_rsp_valid = 1'b0;
            rd_rsp_data = '0;
         end
         #1;
         if (rd_req_valid) any_rd = 1'b1;
         if (wr_valid) any_wr = 1'b1;
         if (rd_req_valid && rd_req_ready) begin
            pend.push_back(rd_req_addr);
            rd_hs++;
         end
         if (wr_valid && wr_ready) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            ws_q.push_back(wr_strb);
         end
         if (irq) irq_cnt++;
      end
   end

   task automatic reg_write(input logic [15:0] a, input logic [31:0] d);
      reg_wr_en = 1'b1;
      reg_addr = a;
      reg_wdata = d;
      @(negedge clk);
      reg_wr_en = 1'b0;
   endtask

   task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
      reg_rd_en = 1'b1;
      reg_addr = a;
      @(negedge clk);
      reg_rd_en = 1'b0;
      d = reg_rdata;
   endtask

   task automatic do_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] l, input logic [31:0] m);
      wa_q.delete();
      wd_q.delete();
      ws_q.delete();
      reg_write(R_A, a);
      reg_write(R_B, b);
      reg_write(R_C, c);
      reg_write(R_LEN, l);
      reg_write(R_START, m);
   endtask

   task automatic wait_irq(input int c0, input string name, output int n);
      n = 0;
      while (irq_cnt == c0 && n < 3000) begin
         @(negedge clk);
         #2;
         n++;
      end
      checks++;
      if (irq_cnt == c0) begin
         errors++;
         $display("FAIL %s timeout: no irq after %0d cycles", name, n);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #1;
      checks++;
      if ({rd_req_valid, wr_valid, irq} !== 3'b000) begin
         errors++;
         $display("FAIL reset_valids: got %b expected 000", {rd_req_valid, wr_valid, irq});
      end
      checks++;
      if (wr_strb !== 32'h0 || reg_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_strb_rdata: got %h/%h expected 0/0", wr_strb, reg_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      reg_read(R_STATUS, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", d); end
      reg_read(R_LEN, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL reset_len: got %h expected 0", d); end
      reg_write(R_B, 32'hCAFE_0123);
      reg_write(16'h18, 32'h1234_5678);
      reg_read(R_B, d);
      checks++;
      if (d !== 32'hCAFE_0123) begin errors++; $display("FAIL b_base_rw: got %h expected cafe0123", d); end
      reg_read(16'h18, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
   endtask

   task automatic test_add_full();
      int c0, n;
      logic [31:0] d;
      c0 = irq_cnt;
      do_job(32'h0, 32'h1000, 32'h201F, 32'd64, 32'd0);
      wait_irq(c0, "add_full", n);
      repeat (3) @(negedge clk);
      checks++;
      if (irq_cnt !== c0 + 1) begin errors++; $display("FAIL add_irq_count: got %0d expected %0d", irq_cnt - c0, 1); end
      checks++;
      if (wa_q.size() !== 8) begin errors++; $display("FAIL add_write_count: got %0d expected 8", wa_q.size()); end
      for (int k = 0; k < wa_q.size(); k++) begin
         checks++;
         if (wa_q[k] !== 64'h2000 + 64'(32 * k)) begin
            errors++;
            $display("FAIL add_addr[%0d]: got %h expected %h", k, wa_q[k], 64'h2000 + 64'(32 * k));
         end
         checks++;
         if (wd_q[k] !== nine || ws_q[k] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL add_data[%0d]: got %h strb %h expected all 9 strb ffffffff", k, wd_q[k], ws_q[k]);
         end
      end
      reg_read(R_STATUS, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL add_status: got %h expected 2", d); end
   endtask

   task automatic test_partial();
      int c0, n;
      c0 = irq_cnt;
      do_job(32'h0, 32'h1000, 32'h2000, 32'd10, 32'd0);
      wait_irq(c0, "partial", n);
      repeat (3) @(negedge clk);
      checks++;
      if (wa_q.size() !== 2) begin errors++; $display("FAIL partial_count: got %0d expected 2", wa_q.size()); end
      else begin
         checks++;
         if (ws_q[0] !== 32'hFFFF_FFFF || ws_q[1] !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL partial_strb: got %h,%h expected ffffffff,000000ff", ws_q[0], ws_q[1]);
         end
         checks++;
         if (wd_q[1][63:0] !== 64'h0000_0009_0000_0009 || wa_q[1] !== 64'h2020) begin
            errors++;
            $display("FAIL partial_word1: got %h at %h expected 0000000900000009 at 2020", wd_q[1][63:0], wa_q[1]);
         end
      end
   endtask

   task automatic test_len_zero();
      int c0, n;
      logic [31:0] d;
      c0 = irq_cnt;
      any_rd = 1'b0;
      any_wr = 1'b0;
      reg_write(R_LEN, 32'd0);
      reg_write(R_START, 32'd0);
      wait_irq(c0, "len_zero", n);
      checks++;
      if (n > 2) begin errors++; $display("FAIL len0_latency: got %0d cycles expected <=2", n); end
      repeat (3) @(negedge clk);
      checks++;
      if ({any_rd, any_wr} !== 2'b00) begin errors++; $display("FAIL len0_traffic: got rd=%b wr=%b expected 0,0", any_rd, any_wr); end
      reg_read(R_STATUS, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL len0_status: got %h expected 2", d); end
   endtask

   task automatic test_start_busy();
      int c0, n;
      logic [31:0] d;
      c0 = irq_cnt;
      do_job(32'h0, 32'h1000, 32'h2000, 32'd64, 32'd0);
      reg_write(R_START, 32'd1);
      reg_write(R_LEN, 32'd10);
      reg_read(R_STATUS, d);
      checks++;
      if (d !== 32'h5) begin errors++; $display("FAIL busy_status: got %h expected 5", d); end
      wait_irq(c0, "start_busy", n);
      repeat (3) @(negedge clk);
      checks++;
      if (wa_q.size() !== 8) begin errors++; $display("FAIL busy_write_count: got %0d expected 8", wa_q.size()); end
      for (int k = 0; k < wa_q.size(); k++) begin
         checks++;
         if (wd_q[k] !== nine) begin errors++; $display("FAIL busy_data[%0d]: got %h expected all 9", k, wd_q[k]); end
      end
      reg_read(R_STATUS, d);
      checks++;
      if (d !== 32'h6) begin errors++; $display("FAIL busy_final_status: got %h expected 6", d); end
      reg_read(R_LEN, d);
      checks++;
      if (d !== 32'd10) begin errors++; $display("FAIL busy_len_reg: got %h expected a", d); end
   endtask

   task automatic one_word(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                           input logic [31:0] exp, input string name);
      int c0, n;
      logic [255:0] got;
      c0 = irq_cnt;
      do_job(a, b, 32'h3000, 32'd8, m);
      wait_irq(c0, name, n);
      repeat (3) @(negedge clk);
      got = (wd_q.size() == 1) ? wd_q[0] : 'x;
      checks++;
      if (got !== {8{exp}}) begin errors++; $display("FAIL %s: got %h expected lanes %h", name, got, exp); end
   endtask

   task automatic test_arith_edges();
      logic [31:0] d;
`ifdef VOP_SATURATE_EN
      one_word(32'h400, 32'h1400, 32'd1, 32'h8000_0000, "sub_min_minus_1");
      one_word(32'h440, 32'h1440, 32'd0, 32'h7FFF_FFFF, "add_max_plus_1");
`else
      one_word(32'h400, 32'h1400, 32'd1, 32'h7FFF_FFFF, "sub_min_minus_1");
      one_word(32'h440, 32'h1440, 32'd0, 32'h8000_0000, "add_max_plus_1");
`endif
      one_word(32'h420, 32'h1420, 32'd2, 32'hFFFF_FFFF, "min_m1_5");
      one_word(32'h420, 32'h1420, 32'd3, 32'd5, "max_m1_5");
      reg_read(R_STATUS, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL err_cleared_status: got %h expected 2", d); end
   endtask

   task automatic test_reset_mid();
      int c0, h0, n;
      logic [31:0] d;
      c0 = irq_cnt;
      h0 = rd_hs;
      do_job(32'h0, 32'h1000, 32'h2000, 32'd64, 32'd0);
      n = 0;
      while (rd_hs < h0 + 2 && n < 500) begin
         @(negedge clk);
         #2;
         n++;
      end
      hold = 1'b1;
      checks++;
      if (rd_hs < h0 + 2) begin errors++; $display("FAIL mid_b_request: got %0d requests expected 2", rd_hs - h0); end
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rd_req_valid, wr_valid, irq, |wr_strb, |reg_rdata} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b expected 00000", {rd_req_valid, wr_valid, irq, |wr_strb, |reg_rdata});
      end
      @(negedge clk);
      rst_n = 1'b1;
      hold = 1'b0;
      n = 0;
      while (pend.size() != 0 && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (irq_cnt !== c0 || wa_q.size() !== 0) begin
         errors++;
         $display("FAIL mid_abort: got irqs=%0d writes=%0d expected 0,0", irq_cnt - c0, wa_q.size());
      end
      reg_read(R_STATUS, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL mid_status: got %h expected 0", d); end
      c0 = irq_cnt;
      do_job(32'h0, 32'h1000, 32'h2000, 32'd16, 32'd0);
      wait_irq(c0, "restart", n);
      repeat (3) @(negedge clk);
      checks++;
      if (wa_q.size() !== 2) begin errors++; $display("FAIL restart_count: got %0d expected 2", wa_q.size()); end
      for (int k = 0; k < wa_q.size(); k++) begin
         checks++;
         if (wd_q[k] !== nine || wa_q[k] !== 64'h2000 + 64'(32 * k)) begin
            errors++;
            $display("FAIL restart_word[%0d]: got %h at %h expected all 9 at %h", k, wd_q[k], wa_q[k], 64'h2000 + 64'(32 * k));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      reg_wr_en = 1'b0;
      reg_rd_en = 1'b0;
      reg_addr = '0;
      reg_wdata = '0;
      for (int k = 0; k < 256; k++) mem[k] = '0;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++) begin
            mem[k][j*32 +: 32] = 32'(j + 1 + 16 * k);
            mem[128 + k][j*32 +: 32] = 32'(8 - j - 16 * k);
         end
      mem[32]  = {8{32'h8000_0000}};
      mem[160] = {8{32'h0000_0001}};
      mem[33]  = {8{32'hFFFF_FFFF}};
      mem[161] = {8{32'h0000_0005}};
      mem[34]  = {8{32'h7FFF_FFFF}};
      mem[162] = {8{32'h0000_0001}};
      repeat (3) @(negedge clk);
      test_reset();
      test_add_full();
      test_partial();
      test_len_zero();
      test_start_busy();
      test_arith_edges();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vector_op_engine.md
VECTOR_OP_ENGINE -- requirements
Module: vector_op_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, memory word width in bits (multiple of LANE_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, card memory byte-address width.
REQ-003 SHALL have parameter LANE_WIDTH, default 32, signed integer lane width; LANES = DATA_WIDTH/LANE_WIDTH.
REQ-004 SHALL have ports clk (input, 1, sole clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-005 SHALL have ports reg_wr_en (input, 1), reg_rd_en (input, 1), reg_addr (input, 16), reg_wdata (input, 32) and reg_rdata (output, 32, registered), forming the register bus.
REQ-006 SHALL have ports rd_req_valid (output, 1), rd_req_ready (input, 1) and rd_req_addr (output, ADDR_WIDTH), forming the read request.
REQ-007 SHALL have ports rd_rsp_valid (input, 1) and rd_rsp_data (input, DATA_WIDTH), forming the in-order read response with no backpressure.
REQ-008 SHALL have ports wr_valid (output, 1), wr_ready (input, 1), wr_addr (output, ADDR_WIDTH), wr_data (output, DATA_WIDTH) and wr_strb (output, DATA_WIDTH/8), forming the write port.
REQ-009 SHALL have port irq (output, 1), a one-cycle completion pulse.

Function
REQ-010 Registers SHALL be: 0x00 START (write), 0x04 A_BASE, 0x08 B_BASE, 0x0C C_BASE, 0x10 LEN (lanes), 0x14 STATUS (read-only: bit0 busy, bit1 done, bit2 start_err); A_BASE through LEN are R/W.
REQ-011 A write to START when idle SHALL latch mode = reg_wdata[1:0] (0 add, 1 sub, 2 min, 3 max, all signed) and begin operation.
REQ-012 A START write while busy SHALL be ignored and SHALL set start_err; start_err clears on the next accepted START.
REQ-013 Base addresses SHALL be zero-extended to ADDR_WIDTH, with the low log2(DATA_WIDTH/8) bits forced to zero.
REQ-014 The FSM SHALL have states IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR and DONE.
REQ-015 FSM transitions SHALL be: IDLE->RD_A on accepted START with LEN!=0; IDLE->DONE on START with LEN==0.
REQ-016 RD_A SHALL move to WAIT_A on rd_req handshake, and WAIT_A SHALL move to RD_B on rd_rsp_valid (A word captured); RD_B/WAIT_B SHALL behave likewise for B.
REQ-017 WAIT_B SHALL move to WR on rd_rsp_valid.
REQ-018 WR SHALL move, on wr handshake, to RD_A if lanes remain, else to DONE; DONE SHALL move to IDLE after one cycle.
REQ-019 Word k SHALL use addresses base + k*(DATA_WIDTH/8), for k = 0..ceil(LEN/LANES)-1.
REQ-020 Lane i of the result SHALL be computed from bits [i*LANE_WIDTH +: LANE_WIDTH] of A and B; arithmetic wraps modulo 2^LANE_WIDTH unless REQ-030 applies.
REQ-021 wr_strb SHALL be all ones, except on a final partial word, where only bytes of the remaining LEN mod LANES lanes are set (low lanes first).
REQ-022 valid/addr/data outputs SHALL hold stable until their ready is seen; rd_rsp_valid outside WAIT_A/WAIT_B SHALL be discarded.
REQ-023 irq SHALL pulse high in DONE; done SHALL be set in DONE and cleared by the next accepted START.
REQ-024 Register writes to A_BASE through LEN while busy SHALL update the registers without affecting the running operation (parameters are latched at START).
REQ-025 reg_rdata SHALL return the addressed register one cycle after reg_rd_en; unmapped addresses SHALL read 0.

Reset
REQ-026 On rst_n low, all registers, STATUS, mode, counters and the FSM (to IDLE) SHALL clear to 0 asynchronously.
REQ-027 On rst_n low, rd_req_valid, wr_valid, irq, wr_strb and reg_rdata SHALL be 0.
REQ-028 Reset mid-operation SHALL abort with no irq; responses arriving after reset deassertion SHALL be discarded.

Configuration
REQ-029 Macro VOP_SATURATE_EN SHALL select add/sub overflow behaviour.
REQ-030 With VOP_SATURATE_EN defined, add/sub SHALL saturate to the signed max/min; without it, they SHALL wrap. min/max are unaffected either way.

Structure
REQ-031 Package vector_op_pkg SHALL hold register offsets, mode encodings and the FSM state typedef.
REQ-032 Sub-module vop_lane_alu (one lane, combinational) SHALL be instantiated LANES times.

Verification
REQ-033 A lanes 1..8, B lanes 8..1, LEN=64, add -> 8 writes at C_BASE+0..0xE0, every lane 9, strb 0xFFFFFFFF, one irq.
REQ-034 LEN=10, add -> 2 writes; the second has wr_strb 0x000000FF.
REQ-035 LEN=0, START -> irq within 2 cycles, no rd_req_valid or wr_valid.
REQ-036 START during busy -> start_err=1, original job completes unchanged.
REQ-037 sub with A=0x80000000, B=1 -> 0x7FFFFFFF without VOP_SATURATE_EN, 0x80000000 with it; min/max of -1,5 -> -1/5.
REQ-038 rst_n low while in WAIT_B, then restart -> FSM IDLE, no irq, new job correct; rd_req_ready/wr_ready randomly stalled throughout.
